// File: rtl/prime_requester_if.sv
// Handshake bundle between prime_requester, the prime generator and the downstream consumer.
// master = requester side, slave = environment (generator + consumer + controller).
interface prime_requester_if #(
    parameter int WIDTH_LOG = 4,
    parameter int CNT_W     = 8
);
    localparam int WIDTH = 1 << WIDTH_LOG;

    logic             start;
    logic [CNT_W-1:0] count;
    logic             pg_go;
    logic             pg_ready;
    logic             pg_error;
    logic [WIDTH-1:0] pg_res;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             done;
    logic             err;
    logic             err_timeout;

    modport master (
        input  start, count, pg_ready, pg_error, pg_res, out_ready,
        output pg_go, out_valid, out_data, busy, done, err, err_timeout
    );

    modport slave (
        output start, count, pg_ready, pg_error, pg_res, out_ready,
        input  pg_go, out_valid, out_data, busy, done, err, err_timeout
    );
endinterface

// File: rtl/prime_requester.sv
// Fetches N consecutive primes from the go/ready prime generator into a small FIFO.
// Optional watchdog on the generator handshake: define PRIMEREQ_TIMEOUT_EN.
module prime_requester #(
    parameter int WIDTH_LOG      = 4,
    parameter int FIFO_DEPTH_LOG = 2,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT        = 1024
) (
    input  logic clk,
    input  logic rst,
    prime_requester_if.master bus
);
    localparam int WIDTH = 1 << WIDTH_LOG;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
    localparam int A     = FIFO_DEPTH_LOG;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_FINISH,
        S_FAIL
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_remaining;
    logic             r_pg_go;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [A:0]       r_wr_ptr;
    logic [A:0]       r_rd_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [A:0]       w_wr_next;
    logic [A:0]       w_rd_next;

`ifdef PRIMEREQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] r_wdog;
    logic            r_err_timeout;
    logic            w_wd_expire;

    assign w_wd_expire     = (r_wdog == WD_W'(TIMEOUT - 1));
    assign bus.err_timeout = r_err_timeout;
`else
    assign bus.err_timeout = 1'b0;
`endif

    always_comb begin
        w_full    = (r_wr_ptr[A] != r_rd_ptr[A]) && (r_wr_ptr[A-1:0] == r_rd_ptr[A-1:0]);
        w_push    = (r_state == S_WAIT_HIGH) && bus.pg_ready && !bus.pg_error;
        w_pop     = r_out_valid && bus.out_ready;
        w_wr_next = r_wr_ptr + {{A{1'b0}}, w_push};
        w_rd_next = r_rd_ptr + {{A{1'b0}}, w_pop};
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[A-1:0]] <= bus.pg_res;
        end
    end

    // out_data is registered: load the post-update head, forwarding the pushed
    // word when the head slot is the one being written this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_wr_ptr    <= w_wr_next;
            r_rd_ptr    <= w_rd_next;
            r_out_valid <= (w_wr_next != w_rd_next);
            if (w_wr_next != w_rd_next) begin
                r_out_data <= (w_push && (w_rd_next == r_wr_ptr)) ? bus.pg_res
                                                                  : r_mem[w_rd_next[A-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_remaining   <= '0;
            r_pg_go       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
`ifdef PRIMEREQ_TIMEOUT_EN
            r_wdog        <= '0;
            r_err_timeout <= 1'b0;
`endif
        end else begin
            r_pg_go <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.count != '0) begin
                            r_remaining   <= bus.count;
                            r_busy        <= 1'b1;
                            r_err         <= 1'b0;
`ifdef PRIMEREQ_TIMEOUT_EN
                            r_err_timeout <= 1'b0;
`endif
                            r_state       <= S_ISSUE;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!w_full && bus.pg_ready) begin
                        r_pg_go <= 1'b1;
                        r_state <= S_WAIT_LOW;
`ifdef PRIMEREQ_TIMEOUT_EN
                        r_wdog  <= '0;
`endif
                    end
                end
                S_WAIT_LOW: begin
`ifdef PRIMEREQ_TIMEOUT_EN
                    r_wdog <= r_wdog + WD_W'(1);
`endif
                    if (!bus.pg_ready) begin
                        r_state <= S_WAIT_HIGH;
                    end
`ifdef PRIMEREQ_TIMEOUT_EN
                    else if (w_wd_expire) begin
                        r_err         <= 1'b1;
                        r_err_timeout <= 1'b1;
                        r_state       <= S_FAIL;
                    end
`endif
                end
                S_WAIT_HIGH: begin
`ifdef PRIMEREQ_TIMEOUT_EN
                    r_wdog <= r_wdog + WD_W'(1);
`endif
                    if (bus.pg_ready) begin
                        if (bus.pg_error) begin
                            r_state <= S_FAIL;
                        end else begin
                            r_remaining <= r_remaining - CNT_W'(1);
                            if (r_remaining == CNT_W'(1)) begin
                                r_done  <= 1'b1;
                                r_state <= S_FINISH;
                            end else begin
                                r_state <= S_ISSUE;
                            end
                        end
                    end
`ifdef PRIMEREQ_TIMEOUT_EN
                    else if (w_wd_expire) begin
                        r_err         <= 1'b1;
                        r_err_timeout <= 1'b1;
                        r_state       <= S_FAIL;
                    end
`endif
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_FAIL: begin
                    r_err   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pg_go     = r_pg_go;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_prime_requester.sv
// Directed bench for prime_requester with a behavioural prime generator model.
module tb_prime_requester;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prime_requester_if #(.WIDTH_LOG(4), .CNT_W(8)) bus_if ();

    prime_requester #(
        .WIDTH_LOG(4),
        .FIFO_DEPTH_LOG(2),
        .CNT_W(8),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // generator model controls
    int err_req = 0;
    bit hang    = 1'b0;

    function automatic logic [15:0] prime_at(int i);
        case (i)
            0: prime_at = 16'd2;
            1: prime_at = 16'd3;
            2: prime_at = 16'd5;
            3: prime_at = 16'd7;
            4: prime_at = 16'd11;
            5: prime_at = 16'd13;
            6: prime_at = 16'd17;
            7: prime_at = 16'd19;
            default: prime_at = 16'd23;
        endcase
    endfunction

    // generator: ready drops the cycle after it sees the go edge, result 4 cycles later
    logic g_prev;
    int   g_lat, g_req, g_idx;
    always @(posedge clk) begin
        if (rst) begin
            bus_if.pg_ready <= 1'b1;
            bus_if.pg_error <= 1'b0;
            bus_if.pg_res   <= 16'd1;
            g_prev <= 1'b0;
            g_lat  <= 0;
            g_req  <= 0;
            g_idx  <= 0;
        end else begin
            g_prev <= bus_if.pg_go;
            if (bus_if.pg_go && !g_prev) begin
                bus_if.pg_ready <= 1'b0;
                bus_if.pg_error <= 1'b0;
                g_lat <= 4;
                g_req <= g_req + 1;
            end else if (g_lat != 0) begin
                if (g_lat == 1) begin
                    if (!hang) begin
                        bus_if.pg_ready <= 1'b1;
                        g_lat <= 0;
                        if (g_req == err_req) begin
                            bus_if.pg_error <= 1'b1;
                        end else begin
                            bus_if.pg_res <= prime_at(g_idx);
                            g_idx <= g_idx + 1;
                        end
                    end
                end else begin
                    g_lat <= g_lat - 1;
                end
            end
        end
    end

    // monitor, sampled mid-cycle
    logic [15:0] got[$];
    int   go_cnt = 0, go_wide = 0, done_cnt = 0;
    logic m_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            m_prev = 1'b0;
        end else begin
            if (bus_if.out_valid && bus_if.out_ready) got.push_back(bus_if.out_data);
            if (bus_if.pg_go && !m_prev) go_cnt++;
            if (bus_if.pg_go && m_prev) go_wide++;
            if (bus_if.done) done_cnt++;
            m_prev = bus_if.pg_go;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (bus_if.done !== 1'b1 && k < 800) begin
            step(1);
            k++;
        end
        chk(tag, bus_if.done, 1);
    endtask

    task automatic pulse_start(input logic [7:0] cnt);
        bus_if.start = 1'b1;
        bus_if.count = cnt;
        step(1);
        bus_if.start = 1'b0;
    endtask

    int exp6[6] = '{2, 3, 5, 7, 11, 13};
    int b_go, b_q, b_done, b_wide, k;

    initial begin
        bus_if.start     = 1'b0;
        bus_if.count     = '0;
        bus_if.out_ready = 1'b0;

        // reset values
        rst = 1'b1;
        step(3);
        chk("rst_pg_go", bus_if.pg_go, 0);
        chk("rst_busy", bus_if.busy, 0);
        chk("rst_done", bus_if.done, 0);
        chk("rst_err", bus_if.err, 0);
        chk("rst_err_timeout", bus_if.err_timeout, 0);
        chk("rst_out_valid", bus_if.out_valid, 0);
        chk("rst_out_data", bus_if.out_data, 0);
        rst = 1'b0;

        // count=5, free-flowing downstream
        b_go = go_cnt; b_q = got.size(); b_done = done_cnt; b_wide = go_wide;
        bus_if.out_ready = 1'b1;
        pulse_start(8'd5);
        chk("t1_busy_after_start", bus_if.busy, 1);
        wait_done("t1_done_seen");
        step(3);
        chk("t1_result_count", got.size() - b_q, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t1_data%0d", i), got[b_q + i], exp6[i]);
        chk("t1_go_count", go_cnt - b_go, 5);
        chk("t1_go_width", go_wide - b_wide, 0);
        chk("t1_done_count", done_cnt - b_done, 1);
        chk("t1_busy_end", bus_if.busy, 0);
        chk("t1_fifo_empty", bus_if.out_valid, 0);

        // backpressure: count=6, depth 4
        do_reset();
        b_go = go_cnt; b_q = got.size(); b_done = done_cnt;
        bus_if.out_ready = 1'b0;
        pulse_start(8'd6);
        step(200);
        chk("t2_go_stalled", go_cnt - b_go, 4);
        chk("t2_out_valid", bus_if.out_valid, 1);
        chk("t2_head_stable", bus_if.out_data, 2);
        chk("t2_busy", bus_if.busy, 1);
        chk("t2_no_done", done_cnt - b_done, 0);
        bus_if.out_ready = 1'b1;
        wait_done("t2_done_seen");
        step(3);
        chk("t2_result_count", got.size() - b_q, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t2_data%0d", i), got[b_q + i], exp6[i]);
        chk("t2_go_count", go_cnt - b_go, 6);
        chk("t2_done_count", done_cnt - b_done, 1);

        // generator error on the 2nd request
        do_reset();
        err_req = 2;
        bus_if.out_ready = 1'b0;
        b_go = go_cnt; b_q = got.size(); b_done = done_cnt;
        pulse_start(8'd5);
        k = 0;
        while (bus_if.err !== 1'b1 && k < 300) begin
            step(1);
            k++;
        end
        chk("t3_err", bus_if.err, 1);
        chk("t3_busy", bus_if.busy, 0);
        step(50);
        chk("t3_go_count", go_cnt - b_go, 2);
        chk("t3_err_sticky", bus_if.err, 1);
        chk("t3_no_done", done_cnt - b_done, 0);
        chk("t3_out_valid", bus_if.out_valid, 1);
        chk("t3_out_data", bus_if.out_data, 2);
        bus_if.out_ready = 1'b1;
        step(1);
        bus_if.out_ready = 1'b0;
        chk("t3_popped_empty", bus_if.out_valid, 0);
        chk("t3_pop_count", got.size() - b_q, 1);
        chk("t3_pop_data", got[b_q], 2);
        err_req = 0;
        pulse_start(8'd1);
        chk("t3_err_cleared", bus_if.err, 0);
        chk("t3_busy_restart", bus_if.busy, 1);
        bus_if.out_ready = 1'b1;
        wait_done("t3_restart_done");
        step(3);

        // count=0
        b_go = go_cnt; b_done = done_cnt;
        pulse_start(8'd0);
        chk("t4_zero_done", bus_if.done, 1);
        chk("t4_zero_busy", bus_if.busy, 0);
        step(1);
        chk("t4_zero_done_drop", bus_if.done, 0);
        step(3);
        chk("t4_zero_go", go_cnt - b_go, 0);
        chk("t4_zero_done_count", done_cnt - b_done, 1);

        // start while busy is ignored
        b_go = go_cnt; b_q = got.size(); b_done = done_cnt;
        pulse_start(8'd3);
        step(4);
        chk("t4_busy_mid", bus_if.busy, 1);
        pulse_start(8'd5);
        wait_done("t4_busy_done");
        step(20);
        chk("t4_ignore_results", got.size() - b_q, 3);
        chk("t4_ignore_go", go_cnt - b_go, 3);
        chk("t4_ignore_done", done_cnt - b_done, 1);
        chk("t4_ignore_busy", bus_if.busy, 0);

        // reset during WAIT_HIGH of the 3rd request
        do_reset();
        b_go = go_cnt;
        bus_if.out_ready = 1'b1;
        pulse_start(8'd5);
        k = 0;
        while (!((go_cnt - b_go) == 3 && bus_if.pg_ready == 1'b0) && k < 300) begin
            step(1);
            k++;
        end
        chk("t5_reach_wait", go_cnt - b_go, 3);
        rst = 1'b1;
        step(1);
        chk("t5_pg_go", bus_if.pg_go, 0);
        chk("t5_busy", bus_if.busy, 0);
        chk("t5_done", bus_if.done, 0);
        chk("t5_err", bus_if.err, 0);
        chk("t5_err_timeout", bus_if.err_timeout, 0);
        chk("t5_out_valid", bus_if.out_valid, 0);
        chk("t5_out_data", bus_if.out_data, 0);
        rst = 1'b0;
        step(20);
        chk("t5_no_go_after", go_cnt - b_go, 3);
        chk("t5_idle_busy", bus_if.busy, 0);

        // generator never answers
        do_reset();
        hang = 1'b1;
        pulse_start(8'd1);
`ifdef PRIMEREQ_TIMEOUT_EN
        k = 0;
        while (bus_if.err !== 1'b1 && k < 40) begin
            step(1);
            k++;
        end
        chk("t6_wd_err", bus_if.err, 1);
        chk("t6_wd_err_timeout", bus_if.err_timeout, 1);
        chk("t6_wd_latency", (k >= 8 && k <= 17) ? 1 : 0, 1);
        step(2);
        chk("t6_wd_busy", bus_if.busy, 0);
`else
        step(1000);
        chk("t6_hang_busy", bus_if.busy, 1);
        chk("t6_hang_err", bus_if.err, 0);
        chk("t6_hang_err_timeout", bus_if.err_timeout, 0);
        chk("t6_hang_pg_go", bus_if.pg_go, 0);
        chk("t6_hang_out_valid", bus_if.out_valid, 0);
`endif
        hang = 1'b0;
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/prime_requester.md
Name: prime_requester

Overview:
- Client-side driver for the prime generator's go/ready/error/res interface.
- Accepts a request for N consecutive primes and issues one go rising edge per prime.
- Waits for each result and buffers results in a small FIFO.
- Presents results downstream over a valid/ready stream, with FIFO backpressure throttling requests to the generator.

Parameters:
- WIDTH_LOG, 4: result width is 1<<WIDTH_LOG bits (WIDTH); must match the generator instance.
- FIFO_DEPTH_LOG, 2: FIFO holds 1<<FIFO_DEPTH_LOG entries.
- CNT_W, 8: width of the request count.
- TIMEOUT, 1024: watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a request; sampled only in IDLE
- count  in  CNT_W  number of primes to fetch; latched on accepted start
- pg_go  out  1  go to the generator; exactly one-cycle high pulse per request
- pg_ready  in  1  generator ready
- pg_error  in  1  generator error; valid when pg_ready=1
- pg_res  in  WIDTH  generator result; valid when pg_ready=1
- out_valid  out  1  FIFO not empty
- out_ready  in  1  downstream accepts head
- out_data  out  WIDTH  FIFO head
- busy  out  1  request in progress
- done  out  1  one-cycle pulse when all count results have been pushed
- err  out  1  sticky error flag
- err_timeout  out  1  sticky; set when err is caused by the watchdog

Behaviour:
- Reset (synchronous, highest priority, including mid-request):
  - state=IDLE; pg_go=0; busy=0; done=0; err=0; err_timeout=0.
  - FIFO emptied (out_valid=0); out_data=0; remaining counter cleared.
- All outputs are registered.
- IDLE:
  - start=1, count!=0: latch remaining=count, busy<=1, clear err/err_timeout, go to ISSUE.
  - start=1, count==0: done pulses the next cycle; no pg_go; stay in IDLE.
- ISSUE:
  - Stall while the FIFO is full or pg_ready=0.
  - Otherwise pg_go<=1 for exactly one cycle, then go to WAIT_LOW.
- WAIT_LOW:
  - pg_go<=0.
  - Wait for pg_ready=0, which the generator drops one cycle after sampling the go edge; then go to WAIT_HIGH.
- WAIT_HIGH: wait for pg_ready=1, then:
  - pg_error=1: go to FAIL.
  - Otherwise push pg_res into the FIFO and decrement remaining.
  - remaining becomes 0: go to FINISH; else go to ISSUE.
- FINISH: done=1 for one cycle, busy<=0, return to IDLE.
- FAIL: err<=1, busy<=0, return to IDLE. No further pg_go. FIFO contents remain readable.
- start while busy is ignored.
- A start accepted while err=1 clears err and err_timeout.
- Minimum spacing between pg_go pulses is 3 cycles: ISSUE, WAIT_LOW, WAIT_HIGH.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address; full/empty derived from the pointers.
  - Pop on out_valid && out_ready.
  - A push never sees full, because ISSUE is gated on not-full; since the FIFO is not full at every push, a pop in the same cycle as a push is always legal.
  - No bypass: out_valid rises the cycle after the push.
  - Data stays stable while out_valid=1 && out_ready=0.
- Latency: pg_ready rising with a valid result -> out_valid=1 after 1 cycle when the FIFO was empty.
- Widths: remaining is CNT_W bits; count values up to 2^CNT_W-1 are supported without wrap.
- The generator's reset state is ready=1, res=1, so the first result after reset is 2.

Optional Feature:
- Macro: PRIMEREQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT_LOW and increments each cycle in WAIT_LOW/WAIT_HIGH.
  - On reaching TIMEOUT it forces FAIL with err=1 and err_timeout=1.
- Undefined:
  - No counter is built; the block waits indefinitely.
  - err_timeout is tied to 0.

Test Plan:
- Reset, then start with count=5, out_ready=1 -> out_data sequence 2,3,5,7,11; five pg_go pulses, each one cycle; done pulses once after the 11 push; busy then 0.
- out_ready=0, count=6, depth 4 -> after 2,3,5,7 are buffered, pg_go stays 0. Then raise out_ready -> remaining 11,13 delivered, then done.
- Generator model answers the 2nd request with pg_ready=1, pg_error=1 -> err=1, busy=0, no further pg_go; the first result 2 is still readable.
- start with count=0 -> done pulse the next cycle, no pg_go, busy stays 0. start pulsed while busy -> ignored; the result count is unchanged.
- Assert rst during WAIT_HIGH of the 3rd request -> next cycle all outputs are at reset values, FIFO empty, pg_go=0.
- With PRIMEREQ_TIMEOUT_EN defined and TIMEOUT=16, generator model holds pg_ready=0 after go -> err=1 and err_timeout=1 within 16 cycles of entering WAIT_LOW; without the macro, the block is still in WAIT_HIGH after 1000 cycles and err_timeout=0.
